// File: rtl/isa_dma_pkg.sv
// Shared constants, register map and FSM state type for the ISA DMA channel engine.
package isa_dma_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_COUNT  = 3'd1;
  localparam logic [2:0] ADDR_FIFO   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_DIR      = 1;
  localparam int CTRL_MASK_LO  = 2;
  localparam int CTRL_AUTOINIT = 6;
  localparam int CTRL_FLUSH    = 7;

  localparam int ST_BUSY    = 0;
  localparam int ST_TC      = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_FULL    = 3;
  localparam int ST_LEVEL   = 4;
  localparam int ST_LAST_CH = 13;
  localparam int ST_OVF     = 15;
  localparam int ST_UNF     = 16;

  localparam logic [1:0] CH_DRQ1 = 2'd0;
  localparam logic [1:0] CH_DRQ3 = 2'd1;
  localparam logic [1:0] CH_DRQ5 = 2'd2;
  localparam logic [1:0] CH_DRQ7 = 2'd3;

  typedef enum logic [2:0] {IDLE, ACK, STROBE, HOLD, REL} dma_state_e;

  // DRQ1/DRQ3 are the 8-bit channels; only the low byte lane carries data.
  function automatic logic is_8bit(input logic [1:0] ch);
    return (ch == CH_DRQ1) || (ch == CH_DRQ3);
  endfunction

endpackage

// File: rtl/isa_dma_fifo.sv
// 16-bit synchronous FIFO with two push and two pop ports (engine = a, host = b), flush and level.
module isa_dma_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push_a,
  input  logic [15:0] wdata_a,
  input  logic        push_b,
  input  logic [15:0] wdata_b,
  input  logic        pop_a,
  input  logic        pop_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  output logic        rd_b_valid,
  output logic        push_drop,
  output logic        pop_drop,
  output logic [8:0]  level,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] TWO_L   = (AW + 1)'(2);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_a_ok, push_b_ok, pop_a_ok, pop_b_ok;

  always_comb begin
    // Port a is served first; port b only sees what a left over (space is judged before pops).
    pop_a_ok  = pop_a && (level_q != '0);
    pop_b_ok  = pop_b && (pop_a_ok ? (level_q >= TWO_L) : (level_q != '0));
    push_a_ok = push_a && (level_q != DEPTH_L);
    push_b_ok = push_b && (push_a_ok ? (level_q < DEPTH_L - 1'b1) : (level_q != DEPTH_L));

    rdata_a    = mem_q[rd_ptr_q];
    rdata_b    = mem_q[pop_a_ok ? rd_ptr_q + AW'(1) : rd_ptr_q];
    rd_b_valid = pop_b_ok;
    push_drop  = ((push_a && !push_a_ok) || (push_b && !push_b_ok)) && !flush;
    pop_drop   = ((pop_a && !pop_a_ok) || (pop_b && !pop_b_ok)) && !flush;

    wr_ptr_d = wr_ptr_q + AW'(push_a_ok) + AW'(push_b_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_a_ok) + AW'(pop_b_ok);
    level_d  = level_q + (AW + 1)'(push_a_ok) + (AW + 1)'(push_b_ok)
                       - (AW + 1)'(pop_a_ok) - (AW + 1)'(pop_b_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_a_ok) mem_q[wr_ptr_q] <= wdata_a;
      if (push_b_ok) mem_q[push_a_ok ? wr_ptr_q + AW'(1) : wr_ptr_q] <= wdata_b;
    end
  end

  assign level = 9'(level_q);
  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

endmodule

// File: rtl/isa_dma_engine.sv
// ISA single-transfer DMA engine: DRQ arbitration, DACK#/AEN/IOR#/IOW# sequencing, FIFO + register window.
// Optional: define DMA_AUTOINIT_EN to implement CTRL autoinit (count reload on terminal count).
module isa_dma_engine
  import isa_dma_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int STROBE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [3:0]  drq,
  output logic [3:0]  dack_n,
  output logic        aen,
  output logic        ior_n,
  output logic        iow_n,
  input  logic [15:0] data_bus_in,
  output logic [15:0] data_bus_out,
  output logic        data_oe,
  output logic        tc
);

  localparam logic [15:0] STB_LAST = 16'(STROBE_CYCLES - 1);

  dma_state_e  state_q, state_d;
  logic [15:0] stb_cnt_q, stb_cnt_d;
  logic [1:0]  ch_q, ch_d, last_ch_q, last_ch_d;
  logic        dir_cyc_q, dir_cyc_d;
  logic [15:0] dout_q, dout_d;
  logic        enable_q, enable_d, dir_q, dir_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] count_q, count_d, reload_q, reload_d;
  logic        tc_flag_q, tc_flag_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0] readdata_q, readdata_d;

  logic        autoinit_rd, unused_bits;
  logic        host_push, host_pop, flush, start, active, tc_set;
  logic        eng_push, eng_pop;
  logic [3:0]  req;
  logic [1:0]  sel_ch;
  logic [15:0] eng_wdata, fifo_rdata_a, fifo_rdata_b;
  logic        fifo_rd_b_valid, fifo_push_drop, fifo_pop_drop, fifo_full, fifo_empty;
  logic [8:0]  fifo_level;

  assign host_push = write && (address == ADDR_FIFO);
  assign host_pop  = read && (address == ADDR_FIFO);
  assign flush     = write && (address == ADDR_CTRL) && writedata[CTRL_FLUSH];
  assign req       = drq & mask_q;
  assign start     = enable_q && (count_q != 16'd0) && (req != 4'd0)
                     && (dir_q ? !fifo_empty : !fifo_full);
  assign eng_wdata = is_8bit(ch_q) ? {8'h00, data_bus_in[7:0]} : data_bus_in;

  isa_dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_a     (eng_push),
    .wdata_a    (eng_wdata),
    .push_b     (host_push),
    .wdata_b    (writedata[15:0]),
    .pop_a      (eng_pop),
    .pop_b      (host_pop),
    .rdata_a    (fifo_rdata_a),
    .rdata_b    (fifo_rdata_b),
    .rd_b_valid (fifo_rd_b_valid),
    .push_drop  (fifo_push_drop),
    .pop_drop   (fifo_pop_drop),
    .level      (fifo_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    sel_ch = CH_DRQ7;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) sel_ch = 2'(i);
    end
  end

  // Channel and direction are latched at cycle start so CTRL writes cannot disturb a transfer.
  always_comb begin
    state_d   = state_q;
    stb_cnt_d = stb_cnt_q;
    ch_d      = ch_q;
    last_ch_d = last_ch_q;
    dir_cyc_d = dir_cyc_q;
    dout_d    = dout_q;
    eng_pop   = 1'b0;
    eng_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACK;
          ch_d      = sel_ch;
          last_ch_d = sel_ch;
          dir_cyc_d = dir_q;
          if (dir_q) begin
            eng_pop = 1'b1;
            dout_d  = is_8bit(sel_ch) ? {8'h00, fifo_rdata_a[7:0]} : fifo_rdata_a;
          end
        end
      end
      ACK: begin
        state_d   = STROBE;
        stb_cnt_d = 16'd0;
      end
      STROBE: begin
        if (stb_cnt_q == STB_LAST) state_d = HOLD;
        else                       stb_cnt_d = stb_cnt_q + 16'd1;
      end
      HOLD: begin
        state_d  = REL;
        eng_push = !dir_cyc_q;
      end
      REL: begin
        state_d = IDLE;
        dout_d  = 16'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d   = enable_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    count_d    = count_q;
    reload_d   = reload_q;
    tc_flag_d  = tc_flag_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    tc_set     = 1'b0;
    readdata_d = 32'd0;

    if (state_q == REL && count_q != 16'd0) begin
      count_d = count_q - 16'd1;
      if (count_q == 16'd1) begin
        tc_set = 1'b1;
`ifdef DMA_AUTOINIT_EN
        if (autoinit_rd) count_d = reload_q;
`endif
      end
    end

    if (write) begin
      case (address)
        ADDR_CTRL: begin
          enable_d = writedata[CTRL_ENABLE];
          dir_d    = writedata[CTRL_DIR];
          mask_d   = writedata[CTRL_MASK_LO +: 4];
        end
        ADDR_COUNT: begin
          count_d  = writedata[15:0];
          reload_d = writedata[15:0];
        end
        ADDR_STATUS: begin
          if (writedata[ST_TC])  tc_flag_d = 1'b0;
          if (writedata[ST_OVF]) ovf_d     = 1'b0;
          if (writedata[ST_UNF]) unf_d     = 1'b0;
        end
        default: ;
      endcase
    end

    if (tc_set)         tc_flag_d = 1'b1;
    if (fifo_push_drop) ovf_d     = 1'b1;
    if (fifo_pop_drop)  unf_d     = 1'b1;

    if (read) begin
      case (address)
        ADDR_CTRL:   readdata_d = {24'd0, 1'b0, autoinit_rd, mask_q, dir_q, enable_q};
        ADDR_COUNT:  readdata_d = {16'd0, count_q};
        ADDR_FIFO:   readdata_d = fifo_rd_b_valid ? {16'd0, fifo_rdata_b} : 32'd0;
        ADDR_STATUS: readdata_d = {15'd0, unf_q, ovf_q, last_ch_q, fifo_level,
                                   fifo_full, fifo_empty, tc_flag_q, (state_q != IDLE)};
        default:     readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      stb_cnt_q  <= '0;
      ch_q       <= '0;
      last_ch_q  <= '0;
      dir_cyc_q  <= 1'b0;
      dout_q     <= '0;
      enable_q   <= 1'b0;
      dir_q      <= 1'b0;
      mask_q     <= '0;
      count_q    <= '0;
      reload_q   <= '0;
      tc_flag_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      stb_cnt_q  <= stb_cnt_d;
      ch_q       <= ch_d;
      last_ch_q  <= last_ch_d;
      dir_cyc_q  <= dir_cyc_d;
      dout_q     <= dout_d;
      enable_q   <= enable_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      tc_flag_q  <= tc_flag_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      readdata_q <= readdata_d;
    end
  end

`ifdef DMA_AUTOINIT_EN
  logic autoinit_q, autoinit_d;

  always_comb begin
    autoinit_d = autoinit_q;
    if (write && address == ADDR_CTRL) autoinit_d = writedata[CTRL_AUTOINIT];
  end

  always_ff @(posedge clk) begin
    if (reset) autoinit_q <= 1'b0;
    else       autoinit_q <= autoinit_d;
  end

  assign autoinit_rd = autoinit_q;
  assign unused_bits = ^writedata[31:17];
`else
  assign autoinit_rd = 1'b0;
  assign unused_bits = ^{writedata[31:17], reload_q};
`endif

  assign active = (state_q == ACK) || (state_q == STROBE) || (state_q == HOLD);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dack
      assign dack_n[gi] = !(active && ch_q == 2'(gi));
    end
  endgenerate

  assign aen          = active;
  assign ior_n        = !(state_q == STROBE && !dir_cyc_q);
  assign iow_n        = !(state_q == STROBE && dir_cyc_q);
  assign data_oe      = active && dir_cyc_q;
  assign data_bus_out = dout_q;
  assign tc           = tc_set;
  assign readdata     = readdata_q;

endmodule

// File: tb/tb_isa_dma_engine.sv
// Self-checking bench for isa_dma_engine: register vector table, DMA monitor with playback/record scoreboards.
module tb_isa_dma_engine;

  localparam int STB = 3;
  localparam logic [2:0] A_CTRL = 3'd0, A_COUNT = 3'd1, A_FIFO = 3'd2, A_STATUS = 3'd3;
`ifdef DMA_AUTOINIT_EN
  localparam logic [31:0] AI_BIT = 32'h40;
`else
  localparam logic [31:0] AI_BIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset, write, read;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [3:0]  drq, dack_n;
  logic        aen, ior_n, iow_n, data_oe, tc;
  logic [15:0] data_bus_in, data_bus_out;

  always #5 clk = ~clk;

  isa_dma_engine #(.FIFO_DEPTH(16), .STROBE_CYCLES(STB)) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .drq          (drq),
    .dack_n       (dack_n),
    .aen          (aen),
    .ior_n        (ior_n),
    .iow_n        (iow_n),
    .data_bus_in  (data_bus_in),
    .data_bus_out (data_bus_out),
    .data_oe      (data_oe),
    .tc           (tc)
  );

  int n_checks = 0, n_fail = 0;
  int n_ior = 0, n_iow = 0, n_tc = 0, cyc = 0, ior_run = 0, iow_run = 0;
  int last_start = 0, prev_start = 0;
  logic [3:0]  last_dack;
  logic        last_aen;
  logic [15:0] pb_exp;
  logic [15:0] exp_rd_q[$];
  logic [15:0] exp_pb_q[$];
  logic [31:0] rd_val;

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    write = 1'b0;
    $display("wr addr=%0d data=0x%08h", a, d);
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    read = 1'b1; address = a;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
    $display("rd addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic fifo_pop_check(input string name);
    logic [31:0] d;
    logic [15:0] e;
    e = 16'h0;
    if (exp_rd_q.size() != 0) e = exp_rd_q.pop_front();
    reg_rd(A_FIFO, d);
    check(name, d, {16'h0, e});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; write = 1'b0; read = 1'b0; drq = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_rd_q.delete();
    exp_pb_q.delete();
    n_ior = 0; n_iow = 0; n_tc = 0;
  endtask

  task automatic wait_ior(input int target, input int limit);
    int i = 0;
    while (n_ior < target && i < limit) begin @(negedge clk); i++; end
    check("wait_ior", n_ior, target);
  endtask

  task automatic wait_tc(input int target, input int limit);
    int i = 0;
    while (n_tc < target && i < limit) begin @(negedge clk); i++; end
    check("wait_tc", n_tc, target);
  endtask

  // Bus monitor: measures strobe widths, counts transfers and tc cycles, checks playback data.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        ior_run = 0;
        iow_run = 0;
      end else begin
        if (tc) n_tc++;
        if (!ior_n) begin
          if (ior_run == 0) begin
            prev_start = last_start; last_start = cyc;
            last_dack = dack_n; last_aen = aen;
          end
          ior_run++;
        end else if (ior_run != 0) begin
          check("ior_len", ior_run, STB);
          n_ior++;
          $display("xfer record dack_n=%b strobe=%0d", last_dack, ior_run);
          ior_run = 0;
        end
        if (!iow_n) begin
          if (iow_run == 0) begin
            last_dack = dack_n; last_aen = aen;
            if (exp_pb_q.size() == 0) check("pb_queue", exp_pb_q.size(), 1);
            else begin
              pb_exp = exp_pb_q.pop_front();
              check("pb_data", data_bus_out, pb_exp);
              check("pb_oe", data_oe, 1);
            end
          end
          iow_run++;
        end else if (iow_run != 0) begin
          check("iow_len", iow_run, STB);
          n_iow++;
          $display("xfer playback dack_n=%b strobe=%0d", last_dack, iow_run);
          iow_run = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; address = 3'd0; writedata = 32'd0;
    drq = 4'h0; data_bus_in = 16'h0;

    vecs[0]  = '{1'b0, A_CTRL,   32'h0,     32'h0};
    vecs[1]  = '{1'b0, A_COUNT,  32'h0,     32'h0};
    vecs[2]  = '{1'b0, A_STATUS, 32'h0,     32'h4};
    vecs[3]  = '{1'b0, 3'd5,     32'h0,     32'h0};
    vecs[4]  = '{1'b1, A_CTRL,   32'hBC,    32'h0};
    vecs[5]  = '{1'b0, A_CTRL,   32'h0,     32'h3C};
    vecs[6]  = '{1'b1, A_COUNT,  32'h12345, 32'h0};
    vecs[7]  = '{1'b0, A_COUNT,  32'h0,     32'h2345};
    vecs[8]  = '{1'b1, 3'd5,     32'hFFFF,  32'h0};
    vecs[9]  = '{1'b0, 3'd5,     32'h0,     32'h0};
    vecs[10] = '{1'b1, A_CTRL,   32'h40,    32'h0};
    vecs[11] = '{1'b0, A_CTRL,   32'h0,     AI_BIT};
    vecs[12] = '{1'b1, A_CTRL,   32'h0,     32'h0};
    vecs[13] = '{1'b0, A_STATUS, 32'h0,     32'h4};
    vecs[14] = '{1'b0, 3'd7,     32'h0,     32'h0};

    do_reset();
    @(negedge clk);
    check("rst_dack_n", dack_n, 4'hF);
    check("rst_ior_n", ior_n, 1);
    check("rst_iow_n", iow_n, 1);
    check("rst_aen", aen, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_dout", data_bus_out, 0);
    check("rst_tc", tc, 0);
    check("rst_readdata", readdata, 0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) reg_wr(vecs[i].addr, vecs[i].wdata);
      else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Record on channel 1, three transfers.
    do_reset();
    data_bus_in = 16'h12AB;
    reg_wr(A_COUNT, 32'd3);
    drq = 4'b0001;
    repeat (3) exp_rd_q.push_back(16'h00AB);
    reg_wr(A_CTRL, 32'h05);
    wait_tc(1, 200);
    repeat (10) @(negedge clk);
    drq = 4'b0000;
    check("rec_n_ior", n_ior, 3);
    check("rec_n_tc", n_tc, 1);
    check("rec_gap", last_start - prev_start, STB + 4);
    check("rec_dack", last_dack, 4'b1110);
    check("rec_aen", last_aen, 1);
    rd_check("rec_status", A_STATUS, 32'h32);
    repeat (3) fifo_pop_check("rec_data");
    rd_check("rec_status_empty", A_STATUS, 32'h6);

    // Playback on channel 7 (16-bit), then channel 1 (8-bit lane).
    do_reset();
    reg_wr(A_FIFO, 32'hBEEF);
    exp_pb_q.push_back(16'hBEEF);
    reg_wr(A_COUNT, 32'd1);
    drq = 4'b1000;
    reg_wr(A_CTRL, 32'h23);
    wait_tc(1, 100);
    check("pb7_dack", last_dack, 4'b0111);
    check("pb7_n_iow", n_iow, 1);
    rd_check("pb7_status", A_STATUS, 32'h6006);
    drq = 4'b0000;
    reg_wr(A_FIFO, 32'h5A5A);
    exp_pb_q.push_back(16'h005A);
    drq = 4'b0001;
    reg_wr(A_COUNT, 32'd1);
    reg_wr(A_CTRL, 32'h07);
    wait_tc(2, 100);
    drq = 4'b0000;
    check("pb1_dack", last_dack, 4'b1110);
    check("pb1_n_iow", n_iow, 2);

    // Priority: DRQ3 beats DRQ7.
    do_reset();
    data_bus_in = 16'h12AB;
    reg_wr(A_COUNT, 32'd1);
    drq = 4'b1010;
    exp_rd_q.push_back(16'h00AB);
    reg_wr(A_CTRL, 32'h3D);
    wait_tc(1, 100);
    drq = 4'b0000;
    check("prio_dack", last_dack, 4'b1101);
    rd_check("prio_status", A_STATUS, 32'h2012);
    fifo_pop_check("prio_data");

    // FIFO full stalls record; one pop allows exactly one more transfer.
    do_reset();
    data_bus_in = 16'h12AB;
    reg_wr(A_COUNT, 32'd20);
    drq = 4'b0100;
    repeat (17) exp_rd_q.push_back(16'h12AB);
    reg_wr(A_CTRL, 32'h11);
    wait_ior(16, 400);
    repeat (30) @(negedge clk);
    check("full_stall", n_ior, 16);
    rd_check("full_status", A_STATUS, 32'h4108);
    fifo_pop_check("full_pop");
    repeat (30) @(negedge clk);
    check("full_one_more", n_ior, 17);
    rd_check("full_status2", A_STATUS, 32'h4108);
    rd_check("full_count", A_COUNT, 32'd3);
    drq = 4'b0000;

    // Underflow / overflow / W1C / flush.
    do_reset();
    rd_check("unf_data", A_FIFO, 32'h0);
    rd_check("unf_status", A_STATUS, 32'h10004);
    for (int i = 0; i < 17; i++) begin
      reg_wr(A_FIFO, 32'(i) | 32'hA000);
      if (i < 16) exp_rd_q.push_back(16'(i) | 16'hA000);
    end
    rd_check("ovf_status", A_STATUS, 32'h18108);
    reg_wr(A_STATUS, 32'h18002);
    rd_check("w1c_status", A_STATUS, 32'h108);
    fifo_pop_check("order0");
    fifo_pop_check("order1");
    rd_check("level14", A_STATUS, 32'hE0);
    reg_wr(A_CTRL, 32'h80);
    rd_check("flush_status", A_STATUS, 32'h4);

    // Autoinit behaviour depends on the build.
    do_reset();
    data_bus_in = 16'h0011;
    reg_wr(A_COUNT, 32'd2);
    drq = 4'b0001;
    reg_wr(A_CTRL, 32'h45);
    rd_check("ai_ctrl", A_CTRL, 32'h05 | AI_BIT);
`ifdef DMA_AUTOINIT_EN
    wait_tc(3, 400);
    check("ai_n_ior", n_ior, 6);
    drq = 4'b0000;
    repeat (10) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    check("noai_n_ior", n_ior, 2);
    check("noai_n_tc", n_tc, 1);
    rd_check("noai_count", A_COUNT, 32'd0);
    rd_check("noai_busy", A_STATUS, 32'h22);
    drq = 4'b0000;
`endif

    // Reset in the middle of a strobe.
    do_reset();
    reg_wr(A_COUNT, 32'd5);
    drq = 4'b0001;
    reg_wr(A_CTRL, 32'h05);
    for (int i = 0; i < 50 && ior_n; i++) @(negedge clk);
    check("midrst_strobe", ior_n, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_dack_n", dack_n, 4'hF);
    check("midrst_aen", aen, 0);
    check("midrst_ior_n", ior_n, 1);
    check("midrst_oe", data_oe, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drq = 4'b0000;
    rd_check("midrst_status", A_STATUS, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_dma_engine.md
Name: isa_dma_engine

Overview:
ISA DMA channel engine sitting alongside the ISA bus interface on the HPS-to-ISA bridge. It services the card's DRQ1/3/5/7 lines, drives DACK#, AEN, IOR#/IOW# for single-transfer DMA cycles, and buffers data in a FIFO. The HPS accesses that FIFO through an Avalon-style register window on the 8 MHz bus clock. Record moves card data into the FIFO with IOR#. Playback moves FIFO data to the card with IOW#.

Parameters:
FIFO_DEPTH, 16, FIFO entries (power of two, 4..256)
STROBE_CYCLES, 3, clk cycles IOR#/IOW# held low (>=1)

Ports:
clk  input  1  bus clock (8 MHz domain)
reset  input  1  synchronous, active-high
write  input  1  register write strobe, single cycle
read  input  1  register read strobe, single cycle
address  input  3  register select
writedata  input  32  register write data
readdata  output  32  register read data, valid 1 cycle after read
drq  input  4  DMA requests {DRQ7,DRQ5,DRQ3,DRQ1}, active-high
dack_n  output  4  DMA acknowledges, active-low, same bit order
aen  output  1  high while a DMA cycle owns the bus
ior_n  output  1  I/O read strobe, active-low
iow_n  output  1  I/O write strobe, active-low
data_bus_in  input  16  ISA data in
data_bus_out  output  16  ISA data out
data_oe  output  1  high when data_bus_out must be driven
tc  output  1  terminal-count pulse, 1 clk

Behaviour:
- Reset values: dack_n=4'hF, ior_n=1, iow_n=1, aen=0, data_oe=0, data_bus_out=0, tc=0, readdata=0. All registers clear. FIFO empty. State IDLE.
- Register map:
  - 0 CTRL RW: [0] enable, [1] dir (0 record, 1 playback), [5:2] channel enable mask, [6] autoinit, [7] flush (write-only, self-clearing).
  - 1 COUNT RW: [15:0] transfers. A write loads both the current and the reload value. Reads return the current value.
  - 2 FIFO: write pushes writedata[15:0]; read pops.
  - 3 STATUS: [0] busy, [1] tc_flag (W1C), [2] empty, [3] full, [12:4] level, [14:13] last channel index, [15] overflow (W1C), [16] underflow (W1C).
  - Addresses 4-7 read 0; writes to them are ignored.
- FIFO rules:
  - Push when full: dropped, sets overflow.
  - Pop when empty: returns 0, sets underflow.
  - Flush empties the FIFO in 1 cycle and overrides a same-cycle push or pop.
  - HPS access and engine access in the same cycle are both honoured.
- Arbitration: fixed priority DRQ1 > DRQ3 > DRQ5 > DRQ7, masked by the channel enable mask. Sampled in IDLE only.
- Start condition for a cycle: enable=1, count!=0, at least one enabled drq high, and FIFO not full (record) or not empty (playback).
- State machine:
  - IDLE: wait for the start condition -> ACK.
  - ACK: dack_n[ch]=0, aen=1. In playback, data_oe=1 and the FIFO head is popped onto data_bus_out. 1 cycle -> STROBE.
  - STROBE: ior_n or iow_n=0 for STROBE_CYCLES cycles -> HOLD.
  - HOLD: strobe deasserted. In record, data_bus_in is captured into the FIFO on this cycle. dack_n and aen stay asserted. 1 cycle -> REL.
  - REL: dack_n=all 1, aen=0, data_oe=0. Count decrements by 1.
    - Count reaches 0: tc pulses, tc_flag is set, and autoinit reloads count.
    - Then -> IDLE.
- Total cycle time is STROBE_CYCLES+3 clk. Back-to-back transfers go through IDLE (minimum 1 idle clk).
- Channels 1/3 are 8-bit: record stores {8'h00, D[7:0]}; playback drives D[15:8]=0. Channels 5/7 are 16-bit full width.
- Clearing enable or writing COUNT mid-cycle does not abort the cycle in progress. It takes effect at the next IDLE. A COUNT write takes priority over the REL decrement in the same cycle.
- busy=1 in every state except IDLE.
- reset mid-cycle returns all outputs to reset values on the next clk edge.

Optional Feature:
- Macro DMA_AUTOINIT_EN.
- Defined: CTRL[6] is implemented, and on TC the count reloads from the reload value so the engine keeps running.
- Undefined: CTRL[6] reads 0 and writes to it are ignored. On TC the count stays 0 and the engine stops until COUNT is rewritten.

Decomposition:
- Package isa_dma_pkg:
  - register address constants (CTRL, COUNT, FIFO, STATUS)
  - CTRL/STATUS bit-index constants
  - state enum (IDLE, ACK, STROBE, HOLD, REL)
  - channel index constants
- Sub-module isa_dma_fifo: synchronous FIFO with width 16, depth FIFO_DEPTH, flush, level, full, and empty outputs.

Test Plan:
- Record on ch1: COUNT=3, CTRL=0x05, drq=4'b0001 held, data_bus_in=0x12AB. Expect 3 cycles each with ior_n low for 3 clk, FIFO holding 0x00AB x3, tc pulse after the 3rd, busy=0.
- Playback on ch7: push 0xBEEF, COUNT=1, CTRL=0x23, drq[3]=1. Expect dack_n=4'b0111, iow_n low for 3 clk, data_bus_out=0xBEEF with data_oe=1, tc=1, FIFO empty.
- Priority: drq=4'b1010, mask=0xF. Expect the DRQ3 channel (dack_n=4'b1101) serviced first and STATUS[14:13]=1.
- FIFO full in record: fill 16 entries. Expect no new ACK while drq is high. Pop one, then exactly one cycle runs.
- Underflow/overflow: read FIFO when empty -> readdata 0 and STATUS[16]=1. A 17th push -> STATUS[15]=1. W1C clears both.
- Autoinit (macro defined): COUNT=2, CTRL[6]=1, drq held. Expect a tc pulse every 2 transfers and continuous operation. With the macro undefined, the engine stops after 2.
